// File: rtl/fcvt_pipe_if.sv
// Request/result handshake bundle for the float-to-int conversion pipe.
// The slave side is the converter; the master side is the issuing/writeback logic.
interface fcvt_pipe_if #(
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_x;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_y;
   logic [TAG_W-1:0] out_tag;
   logic             out_ovf;

   modport slave (
      input  in_valid, in_x, in_tag, out_ready,
      output in_ready, out_valid, out_y, out_tag, out_ovf
   );

   modport master (
      output in_valid, in_x, in_tag, out_ready,
      input  in_ready, out_valid, out_y, out_tag, out_ovf
   );
endinterface

// File: rtl/fcvt_pipe.sv
// Two-stage single-precision float to 32-bit signed integer converter
// (round half away from zero), valid/ready on both sides, with flush.
module fcvt_pipe #(
   parameter int TAG_W = 5
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush,
   fcvt_pipe_if.slave  bus
);
   logic             s1_v;
   logic [31:0]      s1_x;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_v;
   logic [31:0]      s2_y;
   logic [TAG_W-1:0] s2_tag;
   logic             s2_ovf;

   logic             s2_adv;
   logic             s1_adv;

   logic             sgn;
   logic [7:0]       expo;
   logic [23:0]      m1;
   logic [32:0]      t;
   logic [32:0]      t_inc;
   logic [31:0]      mag;
   logic [31:0]      y_c;
   logic             ovf_c;

   assign s2_adv = !s2_v || bus.out_ready;
   assign s1_adv = !s1_v || s2_adv;

   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s2_v;
   assign bus.out_y     = s2_y;
   assign bus.out_tag   = s2_tag;
   assign bus.out_ovf   = s2_ovf;

   // Fixed-point alignment: m1 carries one extra fraction bit below the
   // integer LSB so the +1 / drop-LSB step rounds half away from zero.
   always_comb begin
      sgn   = s1_x[31];
      expo  = s1_x[30:23];
      m1    = {1'b1, s1_x[22:0]};
      t     = '0;
      if (expo < 8'd149) begin
         t = {9'd0, m1} >> (8'd149 - expo);
      end else begin
         t = {9'd0, m1} << (8'd149 < expo ? expo - 8'd149 : 8'd0);
      end
      t_inc = t + 33'd1;
      mag   = t_inc[32:1];
      y_c   = sgn ? (32'd0 - mag) : mag;
      ovf_c = (expo >= 8'd158);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else if (flush) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         if (s2_adv) s2_v <= s1_v;
         if (s1_adv) s1_v <= bus.in_valid;
      end
   end

   // Input holding register; contents only matter while s1_v is set.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_x   <= '0;
         s1_tag <= '0;
      end else if (!flush && s1_adv && bus.in_valid) begin
         s1_x   <= bus.in_x;
         s1_tag <= bus.in_tag;
      end
   end

   // Result register stays put while the writeback side stalls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_y   <= '0;
         s2_tag <= '0;
         s2_ovf <= 1'b0;
      end else if (!flush && s2_adv && s1_v) begin
         s2_y   <= y_c;
         s2_tag <= s1_tag;
         s2_ovf <= ovf_c;
      end
   end
endmodule

// File: tb/tb_fcvt_pipe.sv
// Directed bench for fcvt_pipe: latency, streaming, back-pressure, rounding
// and overflow corners, flush and asynchronous reset.
module tb_fcvt_pipe;
   logic clk = 1'b0;
   logic rstn;
   logic flush;

   fcvt_pipe_if #(.TAG_W(5)) bus ();

   fcvt_pipe #(.TAG_W(5)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] q_x   [8];
   logic [4:0]  q_tag [8];
   logic [31:0] q_y   [8];
   logic [31:0] r_y   [8];
   logic [4:0]  r_tag [8];
   int          r_cyc [8];
   int          n_items, sent, got, cyc_n, leak;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input int n);
      n_items = n;
      sent    = 0;
      got     = 0;
      cyc_n   = 0;
   endtask

   // One clock of streaming: offer the next queued item, log any result taken.
   task automatic cyc();
      logic fi, fo;
      bus.in_valid = (sent < n_items);
      if (sent < n_items) begin
         bus.in_x   = q_x[sent];
         bus.in_tag = q_tag[sent];
      end
      #1;
      fi = bus.in_valid && bus.in_ready;
      fo = bus.out_valid && bus.out_ready;
      if (fo && got < 8) begin
         r_y[got]   = bus.out_y;
         r_tag[got] = bus.out_tag;
         r_cyc[got] = cyc_n;
      end
      if (fo) got++;
      @(posedge clk); #1;
      cyc_n++;
      if (fi) sent++;
   endtask

   task automatic single(input string nm, input logic [31:0] x, input logic [4:0] tg,
                         input logic [31:0] ey, input logic eo);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_x      = x;
      bus.in_tag    = tg;
      #1;
      check({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check({nm, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      check({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({nm, "_y"},     64'(bus.out_y),     64'(ey));
      check({nm, "_tag"},   64'(bus.out_tag),   64'(tg));
      check({nm, "_ovf"},   64'(bus.out_ovf),   64'(eo));
      @(posedge clk); #1;
   endtask

   initial begin
      rstn          = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;
      #2;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check("rst_out_y",     64'(bus.out_y),     64'd0);
      check("rst_out_tag",   64'(bus.out_tag),   64'd0);
      check("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // Basic latency and conversion corners
      single("one",      32'h3F80_0000, 5'd3,  32'h0000_0001, 1'b0);
      single("ovf158",   32'h4F00_0000, 5'd4,  32'h8000_0000, 1'b1);
      single("max157",   32'h4EFF_FFFF, 5'd5,  32'h7FFF_FF80, 1'b0);
      single("neg2p5",   32'hC020_0000, 5'd6,  32'hFFFF_FFFD, 1'b0);
      single("half",     32'h3F00_0000, 5'd7,  32'h0000_0001, 1'b0);
      single("below_hf", 32'h3EFF_FFFF, 5'd8,  32'h0000_0000, 1'b0);
      single("inf",      32'h7F80_0000, 5'd9,  32'h0000_0000, 1'b1);

      // Back-to-back stream, unstalled
      q_x[0] = 32'h4020_0000; q_tag[0] = 5'd1; q_y[0] = 32'h0000_0003;
      q_x[1] = 32'hBFC0_0000; q_tag[1] = 5'd2; q_y[1] = 32'hFFFF_FFFE;
      q_x[2] = 32'h0000_0000; q_tag[2] = 5'd3; q_y[2] = 32'h0000_0000;
      bus.out_ready = 1'b1;
      start(3);
      for (int i = 0; i < 8; i++) cyc();
      bus.in_valid = 1'b0;
      check("b2b_count", 64'(got), 64'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b_y%0d", i),   64'(r_y[i]),   64'(q_y[i]));
         check($sformatf("b2b_tag%0d", i), 64'(r_tag[i]), 64'(q_tag[i]));
         check($sformatf("b2b_cyc%0d", i), 64'(r_cyc[i]), 64'(i + 2));
      end

      // Back-pressure: two accepted, then stall holds output
      q_x[0] = 32'h3F80_0000; q_tag[0] = 5'd10; q_y[0] = 32'h0000_0001;
      q_x[1] = 32'h4020_0000; q_tag[1] = 5'd11; q_y[1] = 32'h0000_0003;
      q_x[2] = 32'hBFC0_0000; q_tag[2] = 5'd12; q_y[2] = 32'hFFFF_FFFE;
      q_x[3] = 32'h4EFF_FFFF; q_tag[3] = 5'd13; q_y[3] = 32'h7FFF_FF80;
      bus.out_ready = 1'b0;
      start(4);
      for (int i = 0; i < 4; i++) cyc();
      check("bp_sent",     64'(sent), 64'd2);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_hold_y",   64'(bus.out_y),    64'h1);
      check("bp_hold_tag", 64'(bus.out_tag),  64'd10);
      for (int i = 0; i < 3; i++) cyc();
      check("bp_hold_y2",  64'(bus.out_y),    64'h1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) cyc();
      bus.in_valid = 1'b0;
      check("bp_count", 64'(got), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("bp_y%0d", i),   64'(r_y[i]),   64'(q_y[i]));
         check($sformatf("bp_tag%0d", i), 64'(r_tag[i]), 64'(q_tag[i]));
      end

      // Flush with both stages full and a request on the input
      q_x[0] = 32'h3F80_0000; q_tag[0] = 5'd20;
      q_x[1] = 32'h4020_0000; q_tag[1] = 5'd21;
      q_x[2] = 32'hBFC0_0000; q_tag[2] = 5'd22;
      bus.out_ready = 1'b0;
      start(3);
      cyc();
      cyc();
      bus.in_valid = 1'b1;
      bus.in_x     = q_x[2];
      bus.in_tag   = q_tag[2];
      flush        = 1'b1;
      #1;
      check("fl_pre_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk); #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("fl_out_valid", 64'(bus.out_valid), 64'd0);
      check("fl_in_ready",  64'(bus.in_ready),  64'd1);
      bus.out_ready = 1'b1;
      leak = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.out_valid) leak++;
         @(posedge clk); #1;
      end
      check("fl_leak", 64'(leak), 64'd0);
      single("post_fl", 32'h3F80_0000, 5'd23, 32'h0000_0001, 1'b0);

      // Asynchronous reset mid-stream
      q_x[0] = 32'h3F80_0000; q_tag[0] = 5'd30;
      q_x[1] = 32'h4020_0000; q_tag[1] = 5'd31;
      bus.out_ready = 1'b0;
      start(2);
      cyc();
      cyc();
      bus.in_valid = 1'b0;
      check("ar_pre_valid", 64'(bus.out_valid), 64'd1);
      #3;
      rstn = 1'b0;
      #1;
      check("ar_out_valid", 64'(bus.out_valid), 64'd0);
      check("ar_in_ready",  64'(bus.in_ready),  64'd1);
      check("ar_out_tag",   64'(bus.out_tag),   64'd0);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_x      = 32'h4020_0000;
      bus.in_tag    = 5'd7;
      @(posedge clk); #1;
      check("ar_held_valid", 64'(bus.out_valid), 64'd0);
      #2;
      rstn = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("ar_lat1_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      check("ar_valid", 64'(bus.out_valid), 64'd1);
      check("ar_y",     64'(bus.out_y),     64'h3);
      check("ar_tag",   64'(bus.out_tag),   64'd7);
      @(posedge clk); #1;
      check("ar_drained", 64'(bus.out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
